psola_frame_sequencer: RTL and testbench
========================================

// Module: psola_frame_sequencer
// PURPOSE
//  Frame-level controller for the autotune pitch-shift path. Per captured input window it starts
//  the pitch detector, validates the detected period, launches psola_no_bram via a one-cycle
//  new_signal pulse, waits for completion, then plays the shifted output buffer out at audio rate.
//  Sits between the input window buffer, the pitch detector, psola_no_bram and the audio output.
// PARAMETERS
//  WINDOW_SIZE     2048   input window length; output buffer is 2*WINDOW_SIZE
//  MIN_PERIOD      20     smallest period (samples) treated as voiced
//  MAX_PERIOD      1000   largest period treated as voiced; must be < WINDOW_SIZE/2
//  DEFAULT_PERIOD  200    fallback period before any voiced frame has been seen
//  PITCH_TIMEOUT   65535  cycles to wait for pitch_valid before falling back
// PORTS
//  clk_in          in   1   system clock
//  rst_in          in   1   reset, synchronous, active-high
//  frame_ready     in   1   pulse: input window captured and stable
//  frame_release   out  1   pulse: input window may be overwritten
//  pitch_start     out  1   pulse: start pitch detector
//  pitch_valid     in   1   pulse: pitch_period valid
//  pitch_period    in   12  detected period, samples
//  psola_start     out  1   pulse to psola new_signal
//  psola_period    out  12  period to psola; stable from psola_start until next psola_start
//  psola_done      in   1   psola done (level; stale-high until psola sees new_signal)
//  psola_len       in   12  psola output_window_len
//  sample_tick     in   1   audio-rate strobe
//  play_addr       out  12  output-buffer read index, combinational read
//  play_data       in   32  signed out[play_addr]
//  sample_out      out  32  signed audio sample
//  sample_valid    out  1   pulse: sample_out updated
//  voiced          out  1   last frame used a detected (in-range) period
//  overrun         out  1   sticky: frame_ready arrived while busy
//  frames_dropped  out  16  saturating count of dropped frames
// BEHAVIOUR
//  Reset: state IDLE; every output 0 except psola_period=DEFAULT_PERIOD; last_period=DEFAULT_PERIOD.
//   Reset mid-operation aborts immediately; no pulse is emitted in the reset cycle.
//  FSM IDLE -> PITCH -> LAUNCH -> SHIFT -> PLAY -> IDLE.
//  IDLE: frame_ready -> pitch_start=1 next cycle, timeout counter cleared, go PITCH.
//  PITCH: pitch_valid with MIN_PERIOD<=pitch_period<=MAX_PERIOD -> psola_period=last_period=pitch_period,
//   voiced=1; out of range -> psola_period=last_period, voiced=0; counter reaches PITCH_TIMEOUT
//   with no pitch_valid -> same as out of range. Go LAUNCH. Period 0 never reaches psola.
//  LAUNCH: psola_start=1 for exactly one cycle; 2-cycle guard counter loaded; go SHIFT.
//  SHIFT: psola_done ignored while guard nonzero (stale done). Then psola_done=1 -> latch
//   len=psola_len, frame_release pulse, play_addr=0, go PLAY; if psola_len==0 go IDLE instead.
//  PLAY: each sample_tick -> sample_out<=play_data, sample_valid=1 next cycle, play_addr+1.
//   Tick with play_addr==len-1 -> last sample, go IDLE. No ticks -> wait indefinitely.
//  Drop rule: frame_ready in any state but IDLE -> ignored, overrun=1, frames_dropped+1 (saturate
//   at 16'hFFFF). Exception: frame_ready on the same cycle as the final PLAY tick is accepted
//   (go directly to PITCH, pitch_start next cycle), not counted.
//  Simultaneous pitch_valid and timeout: pitch_valid wins.
//  pitch_valid/psola_done outside their states: ignored.
//  Latency: frame_ready -> pitch_start 1 cycle; pitch_valid -> psola_start 2 cycles.
// STRUCTURE
//  psola_pkg: seq_state_t enum {IDLE,PITCH,LAUNCH,SHIFT,PLAY}; PERIOD_W=12; SAMPLE_W=32; ADDR_W.
//  Sub-module psola_playout: play_addr counter, len compare, sample_out/sample_valid register;
//   started by FSM, returns last-sample flag. FSM, period check, timeout, drop logic in top.
// TESTING
//  Voiced: frame_ready, pitch_valid period=150, done after 500 cyc, len=300, ticks every 10
//   -> one psola_start with period 150, voiced=1, exactly 300 samples = out[0..299] in order.
//  Out of range: period=5 after prior voiced 150 -> psola_period=150, voiced=0; first frame ever
//   -> 200.
//  Timeout (PITCH_TIMEOUT=100 in bench): no pitch_valid -> psola_start at 101-102 cyc, period=last.
//  Stale done: hold psola_done=1 across launch -> no exit from SHIFT until done re-asserts after guard.
//  Overrun: 3 frame_ready during SHIFT/PLAY -> overrun=1, frames_dropped=3; frame_ready on final
//   tick -> accepted, pitch_start next cycle, count stays 3.
//  Reset in PLAY at addr 50 -> all outputs reset values next cycle; no further sample_valid.

Source files
------------

// File: rtl/psola_frame_sequencer_pkg.sv
// Shared types and widths for the PSOLA frame sequencer and its playout stage.
// Latency: n/a (types, constants and a pure range-check function only).
// Backpressure: n/a.
package psola_frame_sequencer_pkg;

    localparam int PERIOD_W     = 12;
    localparam int SAMPLE_W     = 32;
    localparam int ADDR_W       = 12;   // output buffer is 2*WINDOW_SIZE = 4096 entries
    localparam int LEN_W        = 12;
    localparam int DROP_W       = 16;
    localparam int GUARD_CYCLES = 2;    // cycles psola_done is distrusted after new_signal

    typedef enum logic [2:0] {
        IDLE,
        PITCH,
        LAUNCH,
        SHIFT,
        PLAY
    } seq_state_t;

    // True when a detected period is usable as a voiced period.
    function automatic logic period_in_range(input logic [PERIOD_W-1:0] p,
                                             input int unsigned lo,
                                             input int unsigned hi);
        int unsigned pv;
        pv = 32'(p);
        return (pv >= lo) && (pv <= hi);
    endfunction

endpackage

// File: rtl/psola_frame_sequencer_if.sv
// Bundle of all frame-sequencer handshake and data signals (window buffer, pitch detector,
// psola core, audio output). Latency: n/a (wires only).
// Backpressure: pulse/strobe protocol; the sequencer drops frames it cannot accept.
interface psola_frame_sequencer_if;
    import psola_frame_sequencer_pkg::*;

    logic                       frame_ready;
    logic                       frame_release;
    logic                       pitch_start;
    logic                       pitch_valid;
    logic [PERIOD_W-1:0]        pitch_period;
    logic                       psola_start;
    logic [PERIOD_W-1:0]        psola_period;
    logic                       psola_done;
    logic [LEN_W-1:0]           psola_len;
    logic                       sample_tick;
    logic [ADDR_W-1:0]          play_addr;
    logic signed [SAMPLE_W-1:0] play_data;
    logic signed [SAMPLE_W-1:0] sample_out;
    logic                       sample_valid;
    logic                       voiced;
    logic                       overrun;
    logic [DROP_W-1:0]          frames_dropped;

    // master: the sequencer itself
    modport master (
        input  frame_ready, pitch_valid, pitch_period, psola_done, psola_len,
               sample_tick, play_data,
        output frame_release, pitch_start, psola_start, psola_period, play_addr,
               sample_out, sample_valid, voiced, overrun, frames_dropped
    );

    // slave: the surrounding audio path
    modport slave (
        output frame_ready, pitch_valid, pitch_period, psola_done, psola_len,
               sample_tick, play_data,
        input  frame_release, pitch_start, psola_start, psola_period, play_addr,
               sample_out, sample_valid, voiced, overrun, frames_dropped
    );

endinterface

// File: rtl/psola_frame_sequencer_playout.sv
// Plays the shifted output buffer at audio rate: address counter, length compare, sample register.
// Latency: sample_tick -> sample_valid_o/sample_o 1 cycle; last_o is combinational with the tick.
// Backpressure: none; runs only while run_i, one sample per tick, idles indefinitely without ticks.
// Ports: clk_i/rst_i (sync active-high), load_i+len_i arm a new buffer, run_i gates ticks,
//        tick_i audio strobe, data_i = out[addr_o], sample_o/sample_valid_o, last_o final tick.
module psola_playout
    import psola_frame_sequencer_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       load_i,
    input  logic [LEN_W-1:0]           len_i,
    input  logic                       run_i,
    input  logic                       tick_i,
    input  logic signed [SAMPLE_W-1:0] data_i,
    output logic [ADDR_W-1:0]          addr_o,
    output logic signed [SAMPLE_W-1:0] sample_o,
    output logic                       sample_valid_o,
    output logic                       last_o
);

    logic [ADDR_W-1:0]          addr_q,   addr_d;
    logic [LEN_W-1:0]           len_q,    len_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic                       valid_q,  valid_d;
    logic                       fire;

    assign fire   = run_i && tick_i;
    // len_q is never 0 while running: a zero-length buffer is never loaded into play.
    assign last_o = fire && (addr_q == (len_q - LEN_W'(1)));

    always_comb begin
        addr_d   = addr_q;
        len_d    = len_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        if (load_i) begin
            addr_d = '0;
            len_d  = len_i;
        end else if (fire) begin
            sample_d = data_i;
            valid_d  = 1'b1;
            addr_d   = last_o ? '0 : addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q   <= '0;
            len_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            len_q    <= len_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign addr_o         = addr_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;

endmodule

// File: rtl/psola_frame_sequencer.sv
// Frame controller for the pitch-shift path: pitch detect, period validation, psola launch, playout.
// Latency: frame_ready -> pitch_start 1 cycle; pitch_valid -> psola_start 2 cycles.
// Backpressure: frames arriving while busy are dropped (sticky overrun, saturating drop count).
// Ports: clk_in/rst_in (sync active-high); bus (master) carries window, pitch, psola and audio signals.
module psola_frame_sequencer
    import psola_frame_sequencer_pkg::*;
#(
    parameter int WINDOW_SIZE    = 2048,
    parameter int MIN_PERIOD     = 20,
    parameter int MAX_PERIOD     = 1000,
    parameter int DEFAULT_PERIOD = 200,
    parameter int PITCH_TIMEOUT  = 65535
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    psola_frame_sequencer_if.master bus
);

    // A period must fit twice inside the window; clamp so a bad MAX_PERIOD cannot exceed that.
    localparam int MAX_OK = (MAX_PERIOD < WINDOW_SIZE / 2) ? MAX_PERIOD : (WINDOW_SIZE / 2 - 1);
    localparam int TO_W   = $clog2(PITCH_TIMEOUT + 1);

    seq_state_t          state_q;
    logic [TO_W-1:0]     to_cnt_q;
    logic [1:0]          guard_q;
    logic                pitch_start_q;
    logic                psola_start_q;
    logic                frame_release_q;
    logic [PERIOD_W-1:0] psola_period_q;
    logic [PERIOD_W-1:0] last_period_q;
    logic                voiced_q;
    logic                overrun_q;
    logic [DROP_W-1:0]   drops_q;

    logic                in_range;
    logic                timeout;
    logic                play_load;
    logic                play_last;
    logic                accept_on_last;
    logic                drop_frame;

    assign in_range = period_in_range(bus.pitch_period,
                                      int'(unsigned'(MIN_PERIOD)),
                                      int'(unsigned'(MAX_OK)));
    // Counter starts at 0 on PITCH entry, so PITCH_TIMEOUT cycles have elapsed at this value.
    assign timeout  = (to_cnt_q == TO_W'(PITCH_TIMEOUT - 1));

    assign play_load = (state_q == SHIFT) && (guard_q == '0) && bus.psola_done
                     && (bus.psola_len != '0);

    // A frame landing on the final playout tick is taken as the next frame, not dropped.
    assign accept_on_last = (state_q == PLAY) && play_last;
    assign drop_frame     = bus.frame_ready && (state_q != IDLE) && !accept_on_last;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q         <= IDLE;
            to_cnt_q        <= '0;
            guard_q         <= '0;
            pitch_start_q   <= 1'b0;
            psola_start_q   <= 1'b0;
            frame_release_q <= 1'b0;
            psola_period_q  <= PERIOD_W'(DEFAULT_PERIOD);
            last_period_q   <= PERIOD_W'(DEFAULT_PERIOD);
            voiced_q        <= 1'b0;
            overrun_q       <= 1'b0;
            drops_q         <= '0;
        end else begin
            pitch_start_q   <= 1'b0;
            psola_start_q   <= 1'b0;
            frame_release_q <= 1'b0;

            if (drop_frame) begin
                overrun_q <= 1'b1;
                if (drops_q != '1) begin
                    drops_q <= drops_q + DROP_W'(1);
                end
            end

            unique case (state_q)
                IDLE: begin
                    if (bus.frame_ready) begin
                        pitch_start_q <= 1'b1;
                        to_cnt_q      <= '0;
                        state_q       <= PITCH;
                    end
                end
                PITCH: begin
                    // pitch_valid has priority over a simultaneous timeout.
                    if (bus.pitch_valid) begin
                        if (in_range) begin
                            psola_period_q <= bus.pitch_period;
                            last_period_q  <= bus.pitch_period;
                            voiced_q       <= 1'b1;
                        end else begin
                            psola_period_q <= last_period_q;
                            voiced_q       <= 1'b0;
                        end
                        state_q <= LAUNCH;
                    end else if (timeout) begin
                        psola_period_q <= last_period_q;
                        voiced_q       <= 1'b0;
                        state_q        <= LAUNCH;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                LAUNCH: begin
                    psola_start_q <= 1'b1;
                    guard_q       <= 2'(GUARD_CYCLES);
                    state_q       <= SHIFT;
                end
                SHIFT: begin
                    // psola_done is still high from the previous frame until psola sees new_signal.
                    if (guard_q != '0) begin
                        guard_q <= guard_q - 2'd1;
                    end else if (bus.psola_done) begin
                        frame_release_q <= 1'b1;
                        state_q         <= (bus.psola_len == '0) ? IDLE : PLAY;
                    end
                end
                PLAY: begin
                    if (play_last) begin
                        if (bus.frame_ready) begin
                            pitch_start_q <= 1'b1;
                            to_cnt_q      <= '0;
                            state_q       <= PITCH;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    psola_playout u_playout (
        .clk_i          (clk_in),
        .rst_i          (rst_in),
        .load_i         (play_load),
        .len_i          (bus.psola_len),
        .run_i          (state_q == PLAY),
        .tick_i         (bus.sample_tick),
        .data_i         (bus.play_data),
        .addr_o         (bus.play_addr),
        .sample_o       (bus.sample_out),
        .sample_valid_o (bus.sample_valid),
        .last_o         (play_last)
    );

    assign bus.pitch_start    = pitch_start_q;
    assign bus.psola_start    = psola_start_q;
    assign bus.frame_release  = frame_release_q;
    assign bus.psola_period   = psola_period_q;
    assign bus.voiced         = voiced_q;
    assign bus.overrun        = overrun_q;
    assign bus.frames_dropped = drops_q;

endmodule

// File: tb/tb_psola_frame_sequencer.sv
module tb_psola_frame_sequencer;

    localparam int MIN_P = 20;
    localparam int MAX_P = 1000;
    localparam int DEF_P = 200;
    localparam int TOUT  = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    psola_frame_sequencer_if bus();

    psola_frame_sequencer #(.PITCH_TIMEOUT(TOUT)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    logic [31:0] out_mem [0:4095];
    assign bus.play_data = out_mem[bus.play_addr];

    int          n_chk   = 0;
    int          n_fail  = 0;
    int          n_start = 0;
    int          n_rel   = 0;
    logic [31:0] sq[$];
    int          model_last = DEF_P;

    // Event recorder: samples played, psola launches, window releases.
    always @(negedge clk) begin
        if (bus.sample_valid)  sq.push_back(bus.sample_out);
        if (bus.psola_start)   n_start++;
        if (bus.frame_release) n_rel++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_pitch_start",   32'(bus.pitch_start), 0);
        chk("rst_psola_start",   32'(bus.psola_start), 0);
        chk("rst_frame_release", 32'(bus.frame_release), 0);
        chk("rst_sample_valid",  32'(bus.sample_valid), 0);
        chk("rst_sample_out",    bus.sample_out, 0);
        chk("rst_play_addr",     32'(bus.play_addr), 0);
        chk("rst_voiced",        32'(bus.voiced), 0);
        chk("rst_overrun",       32'(bus.overrun), 0);
        chk("rst_dropped",       32'(bus.frames_dropped), 0);
        chk("rst_psola_period",  32'(bus.psola_period), DEF_P);
    endtask

    task automatic start_frame();
        bus.frame_ready = 1'b1;
        step();
        bus.frame_ready = 1'b0;
        chk("pitch_start_lat", 32'(bus.pitch_start), 1);
    endtask

    // Model: in-range periods become the new last period; anything else reuses it.
    task automatic give_pitch(input logic [11:0] per);
        int exp_p;
        bit v;
        v     = (int'(per) >= MIN_P) && (int'(per) <= MAX_P);
        exp_p = v ? int'(per) : model_last;
        repeat (3) step();
        bus.pitch_valid  = 1'b1;
        bus.pitch_period = per;
        step();
        bus.pitch_valid  = 1'b0;
        bus.pitch_period = 12'($urandom);
        chk("psola_start_early", 32'(bus.psola_start), 0);
        step();
        chk("psola_start_lat", 32'(bus.psola_start), 1);
        chk("psola_period", 32'(bus.psola_period), exp_p);
        chk("voiced", 32'(bus.voiced), 32'(v));
        model_last = exp_p;
    endtask

    task automatic timeout_pitch();
        int k;
        k = 1;
        bus.pitch_period = 12'($urandom_range(MIN_P, MAX_P));
        while (!bus.psola_start && k < 300) begin
            step();
            k++;
        end
        chk("timeout_start", 32'(bus.psola_start), 1);
        chk("timeout_latency", 32'((k >= 101) && (k <= 102)), 1);
        chk("timeout_period", 32'(bus.psola_period), model_last);
        chk("timeout_voiced", 32'(bus.voiced), 0);
    endtask

    task automatic finish_shift(input logic [11:0] len, input int dly);
        int r0;
        int w;
        r0 = n_rel;
        w  = 0;
        repeat (dly) step();
        chk("no_early_release", n_rel - r0, 0);
        bus.psola_done = 1'b1;
        bus.psola_len  = len;
        while (n_rel == r0 && w < 10) begin
            step();
            w++;
        end
        chk("frame_release", n_rel - r0, 1);
        bus.psola_done = 1'b0;
        bus.psola_len  = 12'($urandom);
    endtask

    task automatic play(input int len, input int n_stop, input int gap, input bit fr_last);
        int b;
        b = 0;
        while (sq.size() < n_stop && b < 30000) begin
            bus.sample_tick = 1'b1;
            if (fr_last && sq.size() == len - 1) bus.frame_ready = 1'b1;
            step();
            b++;
            bus.sample_tick = 1'b0;
            if (bus.frame_ready) begin
                bus.frame_ready = 1'b0;
                chk("pitch_start_after_last", 32'(bus.pitch_start), 1);
            end
            repeat (gap - 1) begin
                step();
                b++;
            end
        end
        chk("play_count", sq.size(), n_stop);
    endtask

    task automatic tail_and_samples(input int len);
        repeat (3) begin
            bus.sample_tick = 1'b1;
            step();
            bus.sample_tick = 1'b0;
            step();
        end
        chk("no_extra_samples", sq.size(), len);
        for (int i = 0; i < len && i < sq.size(); i++) begin
            chk("sample", sq[i], out_mem[i]);
        end
    endtask

    task automatic run_frame(input bit tmo, input logic [11:0] per, input int len,
                             input int dly, input int gap);
        int s0;
        s0 = n_start;
        sq.delete();
        start_frame();
        if (tmo) timeout_pitch();
        else     give_pitch(per);
        finish_shift(12'(len), dly);
        play(len, len, gap, 1'b0);
        tail_and_samples(len);
        chk("one_psola_start", n_start - s0, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] tbl [5];
        int          s0;
        int          r0;
        int          drops;

        for (int i = 0; i < 4096; i++) out_mem[i] = $urandom;
        bus.frame_ready  = 1'b0;
        bus.pitch_valid  = 1'b0;
        bus.pitch_period = '0;
        bus.psola_done   = 1'b0;
        bus.psola_len    = '0;
        bus.sample_tick  = 1'b0;

        // Reset state
        step();
        step();
        chk_reset_outputs();
        rst = 1'b0;
        step();

        // First frame ever, out-of-range period -> default
        run_frame(1'b0, 12'd5, 8, 20, 2);
        // Nominal voiced frame
        run_frame(1'b0, 12'd150, 300, 500, 10);
        // Out of range after a voiced frame -> reuse 150
        run_frame(1'b0, 12'd5, $urandom_range(1, 64), $urandom_range(3, 40), $urandom_range(1, 4));

        // Range boundaries, zero period, random voiced period
        tbl = '{12'd20, 12'd1000, 12'd1001, 12'd0, 12'($urandom_range(MIN_P, MAX_P))};
        for (int i = 0; i < 5; i++) begin
            run_frame(1'b0, tbl[i], $urandom_range(1, 64), $urandom_range(3, 40),
                      $urandom_range(1, 4));
        end

        // Pitch detector never answers
        run_frame(1'b1, 12'd0, $urandom_range(1, 32), 5, 2);
        // Zero-length output: straight back to idle
        run_frame(1'b0, 12'($urandom_range(MIN_P, MAX_P)), 0, 5, 1);

        // Stale psola_done held high across launch
        s0 = n_start;
        sq.delete();
        start_frame();
        bus.psola_done = 1'b1;
        bus.psola_len  = 12'd40;
        give_pitch(12'd300);
        r0 = n_rel;
        step();
        chk("stale_guard1", 32'(bus.frame_release), 0);
        step();
        chk("stale_guard2", 32'(bus.frame_release), 0);
        bus.psola_done = 1'b0;
        repeat (10) step();
        chk("stale_no_exit", n_rel - r0, 0);
        finish_shift(12'd40, 0);
        play(40, 40, 3, 1'b0);
        tail_and_samples(40);
        chk("stale_one_start", n_start - s0, 1);

        // Overrun: one drop in SHIFT, two in PLAY, then frame on final tick accepted
        chk("pre_overrun", 32'(bus.overrun), 0);
        chk("pre_dropped", 32'(bus.frames_dropped), 0);
        drops = 0;
        sq.delete();
        start_frame();
        give_pitch(12'($urandom_range(MIN_P, MAX_P)));
        bus.frame_ready = 1'b1;
        step();
        bus.frame_ready = 1'b0;
        drops++;
        chk("overrun_set", 32'(bus.overrun), 1);
        finish_shift(12'd120, 5);
        play(120, 30, 2, 1'b0);
        repeat (2) begin
            bus.frame_ready = 1'b1;
            step();
            bus.frame_ready = 1'b0;
            drops++;
            step();
        end
        chk("dropped_3", 32'(bus.frames_dropped), drops);
        play(120, 120, 2, 1'b1);
        chk("dropped_after_accept", 32'(bus.frames_dropped), drops);
        chk("overrun_sticky", 32'(bus.overrun), 1);
        for (int i = 0; i < 120; i++) chk("ovr_sample", sq[i], out_mem[i]);

        // The accepted frame: play to address 50, then reset
        sq.delete();
        give_pitch(12'($urandom_range(MIN_P, MAX_P)));
        finish_shift(12'd200, 10);
        play(200, 50, 2, 1'b0);
        chk("addr_before_reset", 32'(bus.play_addr), 50);
        rst = 1'b1;
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        chk_reset_outputs();
        rst = 1'b0;
        model_last = DEF_P;
        repeat (5) begin
            bus.sample_tick = 1'b1;
            step();
            bus.sample_tick = 1'b0;
            step();
        end
        chk("no_samples_after_reset", sq.size(), 50);

        // Last period forgotten by reset -> default again
        run_frame(1'b0, 12'd3000, 10, 5, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
